// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the external memory bus arbiter: FSM states and grant ids.
// Imported by mem_bus_arbiter and its testbench.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int WDOG_W = 8;

    // Winner of a simultaneous request: alternate away from the last owner,
    // or let the D-side win unconditionally when alternation is disabled.
    function automatic logic tie_pick(input logic rr_en, input logic last_grant);
        return rr_en ? ~last_grant : GNT_D;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter for the external memory port with a grant watchdog.
// Optional macro ARB_ROUND_ROBIN_EN: alternate owners on ties instead of fixed D priority.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ARB_IDLE    | bus idle, all outputs 0, sampling requests
// ARB_GRANT_I | I-side owns the bus until i_re drops
// ARB_GRANT_D | D-side owns the bus until d_re and d_wr both drop
// ARB_RELEASE | one dead cycle with all strobes low between owners
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_addr,
    input  logic                 i_re,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_data_in,
    input  logic [31:0]          d_addr,
    input  logic                 d_re,
    input  logic                 d_wr,
    input  logic [WORD_SIZE-1:0] d_data_out,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_data_in,
    output logic [31:0]          ext_addr,
    output logic                 ext_re,
    output logic                 ext_wr,
    output logic [WORD_SIZE-1:0] ext_data_out,
    input  logic [WORD_SIZE-1:0] ext_data_in,
    input  logic                 ext_ack,
    output logic                 bus_err
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    localparam logic [WDOG_W-1:0] WDOG_TC = WDOG_W'(TIMEOUT_CYCLES);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              bus_err_q, bus_err_d;

    logic req_i;
    logic req_d;
    logic granted;
    logic tie_winner;

    assign req_i      = i_re;
    assign req_d      = d_re | d_wr;
    assign granted    = (state_q == ARB_GRANT_I) || (state_q == ARB_GRANT_D);
    assign tie_winner = tie_pick(RR_EN, last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (req_i && req_d) begin
                    state_d      = (tie_winner == GNT_D) ? ARB_GRANT_D : ARB_GRANT_I;
                    last_grant_d = tie_winner;
                end else if (req_d) begin
                    state_d      = ARB_GRANT_D;
                    last_grant_d = GNT_D;
                end else if (req_i) begin
                    state_d      = ARB_GRANT_I;
                    last_grant_d = GNT_I;
                end
            end
            ARB_GRANT_I: if (!req_i) state_d = ARB_RELEASE;
            ARB_GRANT_D: if (!req_d) state_d = ARB_RELEASE;
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    // Watchdog saturates at the terminal count so bus_err fires only on arrival.
    always_comb begin
        if (!granted || ext_ack) begin
            wdog_d = '0;
        end else if (wdog_q == WDOG_TC) begin
            wdog_d = wdog_q;
        end else begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
        bus_err_d = (wdog_d == WDOG_TC) && (wdog_q != WDOG_TC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_I;
            wdog_q       <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;

    // Bus mux is combinational from the registered owner so acks see no extra latency.
    always_comb begin
        ext_addr     = '0;
        ext_re       = 1'b0;
        ext_wr       = 1'b0;
        ext_data_out = '0;
        i_ack        = 1'b0;
        d_ack        = 1'b0;
        i_data_in    = '0;
        d_data_in    = '0;
        unique case (state_q)
            ARB_GRANT_I: begin
                ext_addr  = i_addr;
                ext_re    = i_re;
                i_ack     = ext_ack;
                i_data_in = ext_data_in;
            end
            ARB_GRANT_D: begin
                ext_addr     = d_addr;
                ext_re       = d_re;
                ext_wr       = d_wr;
                ext_data_out = d_data_out;
                d_ack        = ext_ack;
                d_data_in    = ext_data_in;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (watchdog built with an 8-cycle timeout).
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int WS = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   i_addr = '0;
    logic          i_re = 1'b0;
    logic          i_ack;
    logic [WS-1:0] i_data_in;
    logic [31:0]   d_addr = '0;
    logic          d_re = 1'b0;
    logic          d_wr = 1'b0;
    logic [WS-1:0] d_data_out = '0;
    logic          d_ack;
    logic [WS-1:0] d_data_in;
    logic [31:0]   ext_addr;
    logic          ext_re;
    logic          ext_wr;
    logic [WS-1:0] ext_data_out;
    logic [WS-1:0] ext_data_in = 32'h1357_9BDF;
    logic          ext_ack = 1'b0;
    logic          bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_arbiter #(.WORD_SIZE(WS), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_re(i_re), .i_ack(i_ack), .i_data_in(i_data_in),
        .d_addr(d_addr), .d_re(d_re), .d_wr(d_wr), .d_data_out(d_data_out),
        .d_ack(d_ack), .d_data_in(d_data_in),
        .ext_addr(ext_addr), .ext_re(ext_re), .ext_wr(ext_wr),
        .ext_data_out(ext_data_out), .ext_data_in(ext_data_in), .ext_ack(ext_ack),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ext_re, ext_wr, i_ack, d_ack, bus_err}
    function automatic logic [4:0] strobes();
        return {ext_re, ext_wr, i_ack, d_ack, bus_err};
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_strb"}, 64'(strobes()), 64'd0);
        chk({tag, "_addr"}, 64'(ext_addr), 64'd0);
        chk({tag, "_data"}, {ext_data_out, i_data_in | d_data_in}, 64'd0);
    endtask

    task automatic release_bus(input string tag);
        i_re = 1'b0; d_re = 1'b0; d_wr = 1'b0; ext_ack = 1'b0;
        tick();
        chk({tag, "_rel_st"}, 64'(dut.state_q), 64'(ARB_RELEASE));
        chk_quiet({tag, "_rel"});
        tick();
        chk({tag, "_idle_st"}, 64'(dut.state_q), 64'(ARB_IDLE));
    endtask

    initial begin
        arb_state_e tie_exp [3];
`ifdef ARB_ROUND_ROBIN_EN
        tie_exp = '{ARB_GRANT_D, ARB_GRANT_I, ARB_GRANT_D};
`else
        tie_exp = '{ARB_GRANT_D, ARB_GRANT_D, ARB_GRANT_D};
`endif

        // Reset values while reset is held
        tick();
        tick();
        chk("rst_st", 64'(dut.state_q), 64'(ARB_IDLE));
        chk_quiet("rst");
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a D write
        d_wr = 1'b1; d_addr = 32'h40; d_data_out = 32'h1234_5678;
        tick();
        chk("t1_grant_d", 64'(dut.state_q), 64'(ARB_GRANT_D));
        chk("t1_wr", 64'(strobes()), 64'b01000);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_rst_st", 64'(dut.state_q), 64'(ARB_IDLE));
        chk_quiet("t1_rst");
        d_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        i_re = 1'b1; i_addr = 32'h200;
        tick();
        chk("t1_grant_i", 64'(dut.state_q), 64'(ARB_GRANT_I));
        chk("t1_i_addr", 64'(ext_addr), 64'h200);
        release_bus("t1");

        // Ack while idle is dropped
        ext_ack = 1'b1;
        #1;
        chk("idle_ack", 64'(strobes()), 64'd0);
        ext_ack = 1'b0;

        // I-side 16-word burst, ack every second cycle
        i_re = 1'b1; i_addr = 32'h1000;
        tick();
        chk("t2_grant", 64'(dut.state_q), 64'(ARB_GRANT_I));
        for (int k = 0; k < 32; k++) begin
            i_addr      = 32'h1000 + 32'(4 * (k / 2));
            ext_ack     = logic'(k % 2);
            ext_data_in = 32'hA000_0000 + 32'(k);
            #1;
            chk("t2_addr", 64'(ext_addr), 64'(32'h1000 + 32'(4 * (k / 2))));
            chk("t2_strb", 64'(strobes()), {59'd0, 1'b1, 1'b0, logic'(k % 2), 1'b0, 1'b0});
            if (k % 2 == 1) begin
                chk("t2_data", {i_data_in, d_data_in}, {32'hA000_0000 + 32'(k), 32'h0});
            end
            tick();
        end
        release_bus("t2");

        // D-side write
        d_wr = 1'b1; d_addr = 32'h80; d_data_out = 32'hDEAD_BEEF;
        tick();
        chk("t3_grant", 64'(dut.state_q), 64'(ARB_GRANT_D));
        chk("t3_strb", 64'(strobes()), 64'b01000);
        chk("t3_wdata", 64'(ext_data_out), 64'hDEAD_BEEF);
        chk("t3_addr", 64'(ext_addr), 64'h80);
        ext_ack = 1'b1; ext_data_in = 32'h5555_AAAA;
        #1;
        chk("t3_ack", 64'(strobes()), 64'b01010);
        chk("t3_rdata", {i_data_in, d_data_in}, {32'h0, 32'h5555_AAAA});
        release_bus("t3");

        // Three ties from a fresh last_grant
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            i_re = 1'b1; d_re = 1'b1; i_addr = 32'h111; d_addr = 32'h222;
            tick();
            chk("t4_tie", 64'(dut.state_q), 64'(tie_exp[t]));
            chk("t4_addr", 64'(ext_addr), (tie_exp[t] == ARB_GRANT_D) ? 64'h222 : 64'h111);
            release_bus("t4");
        end

        // Watchdog: no ack for a D read
        d_re = 1'b1; d_addr = 32'h900;
        tick();
        chk("t5_grant", 64'(dut.state_q), 64'(ARB_GRANT_D));
        chk("t5_err0", 64'(bus_err), 64'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t5_err", 64'(bus_err), (k == 8) ? 64'd1 : 64'd0);
            chk("t5_hold", 64'(dut.state_q), 64'(ARB_GRANT_D));
        end
        release_bus("t5");

        // I request rising during a D burst waits for D to finish
        d_re = 1'b1; d_addr = 32'h300;
        tick();
        chk("t6_grant_d", 64'(dut.state_q), 64'(ARB_GRANT_D));
        i_re = 1'b1; i_addr = 32'h700; ext_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_hold", 64'(dut.state_q), 64'(ARB_GRANT_D));
            chk("t6_strb", 64'(strobes()), 64'b10010);
            chk("t6_addr", 64'(ext_addr), 64'h300);
        end
        d_re = 1'b0; ext_ack = 1'b0;
        tick();
        chk("t6_rel", 64'(dut.state_q), 64'(ARB_RELEASE));
        chk_quiet("t6_rel");
        tick();
        chk("t6_idle", 64'(dut.state_q), 64'(ARB_IDLE));
        tick();
        chk("t6_grant_i", 64'(dut.state_q), 64'(ARB_GRANT_I));
        chk("t6_i_addr", 64'(ext_addr), 64'h700);
        release_bus("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
